// File: rtl/bit_serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop, computing a - b - bin LSB first.
// Optional macro BIT_SERIAL_SUB_SAT_EN clamps diff to zero on a final unsigned borrow.
module bit_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             a0;
  logic             b0;
  logic             d;
  logic             br_next;
  logic             last;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs; the new bit enters the result from the MSB end
  always_comb begin
    a0       = a_sr[0];
    b0       = b_sr[0];
    d        = a0 ^ b0 ^ br;
    br_next  = (~a0 & b0) | (~a0 & br) | (b0 & br);
    last     = (cnt == LAST);
    res_next = {d, res_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // diff/bout/ovf only change on the completing edge, so partial results never leak out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= bin;
            res_sr <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= res_next;
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          if (last) begin
`ifdef BIT_SERIAL_SUB_SAT_EN
            diff <= br_next ? '0 : res_next;
`else
            diff <= res_next;
`endif
            bout <= br_next;
            ovf  <= br ^ br_next;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_sub.sv
// Self-checking bench for bit_serial_sub (WIDTH=8): vector table, scoreboard queue, corner sequences.
module tb_bit_serial_sub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  exp_t exp_q[$];
  vec_t vecs[9];

  bit_serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [W-1:0] satDiff(logic [W-1:0] d, logic bo);
`ifdef BIT_SERIAL_SUB_SAT_EN
    return bo ? '0 : d;
`else
    return d;
`endif
  endfunction

  // Independent arithmetic model: wide unsigned and signed-integer subtraction
  function automatic exp_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic mbin);
    exp_t     r;
    logic [W:0] full;
    int       s;
    full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    s      = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    r.diff = satDiff(full[W-1:0], full[W]);
    r.bout = full[W];
    r.ovf  = (s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1);
    return r;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(logic [W-1:0] ta, logic [W-1:0] tb_, logic tbin, exp_t e);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    accept_cyc = cyc;
    exp_q.push_back(e);
    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
    checkOutput("done_low_after_start", {31'b0, done}, 32'd0);
  endtask

  task automatic waitResult(string name);
    exp_t e;
    int   n = 0;
    while (!done && n < 3 * W) begin
      if (!busy) checkOutput({name, "_busy_during_run"}, {31'b0, busy}, 32'd1);
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_done_seen"}, {31'b0, done}, 32'd1);
    if (done && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({name, "_latency"}, 32'(cyc - accept_cyc), 32'(W));
      checkOutput({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
      checkOutput({name, "_diff"}, {24'b0, diff}, {24'b0, e.diff});
      checkOutput({name, "_bout"}, {31'b0, bout}, {31'b0, e.bout});
      checkOutput({name, "_ovf"}, {31'b0, ovf}, {31'b0, e.ovf});
    end
  endtask

  function automatic exp_t fromVec(vec_t v);
    exp_t e;
    e.diff = satDiff(v.diff, v.bout);
    e.bout = v.bout;
    e.ovf  = v.ovf;
    return e;
  endfunction

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    logic         rbin;

    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[8] = '{8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0};

    #3;
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_diff", {24'b0, diff}, 32'd0);
    checkOutput("reset_bout_ovf", {30'b0, bout, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, fromVec(vecs[i]));
      waitResult($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_done_one_cycle", i), {31'b0, done}, 32'd0);
    end

    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      applyStimulus(ra, rb, rbin, model(ra, rb, rbin));
      waitResult($sformatf("rand%0d", i));
    end

    // start held high while busy with different operands must be ignored
    applyStimulus(8'h5A, 8'h23, 1'b0, model(8'h5A, 8'h23, 1'b0));
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; bin = 1'b1; start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    waitResult("ignore_start");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("ignore_single_done", {30'b0, done, busy}, 32'd0);
    end
    checkOutput("ignore_diff_held", {24'b0, diff}, 32'h37);

    // reset mid-run abandons the operation with no done pulse
    applyStimulus(8'h5A, 8'h23, 1'b0, model(8'h5A, 8'h23, 1'b0));
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    checkOutput("abort_busy_done", {30'b0, busy, done}, 32'd0);
    checkOutput("abort_diff", {24'b0, diff}, 32'd0);
    checkOutput("abort_bout_ovf", {30'b0, bout, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_done", {31'b0, done}, 32'd0);
    end
    applyStimulus(8'h09, 8'h04, 1'b0, model(8'h09, 8'h04, 1'b0));
    waitResult("after_abort");

    // back-to-back: start in the done cycle, old result held until the new completion
    applyStimulus(8'h5A, 8'h23, 1'b0, model(8'h5A, 8'h23, 1'b0));
    waitResult("b2b_first");
    applyStimulus(8'h01, 8'h02, 1'b0, model(8'h01, 8'h02, 1'b0));
    checkOutput("b2b_diff_held", {24'b0, diff}, 32'h37);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("b2b_diff_held_mid", {24'b0, diff}, 32'h37);
    waitResult("b2b_second");
    checkOutput("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
